// File: rtl/pwm_meter_pkg.sv
// Shared constants and FSM encoding for the PWM duty-cycle meter.
package pwm_meter_pkg;

  localparam int DUTY_SCALE = 1000;
  localparam int DUTY_W     = 10;
  localparam int DIV_CYCLES = 10;
  localparam int FILT_LEN   = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/pwm_seq_divider.sv
// Restoring shift-subtract divider producing a DUTY_W-bit quotient, one bit per cycle.
module pwm_seq_divider
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W+DUTY_W-1:0] numerator,
  input  logic [CNT_W-1:0]        denominator,
  output logic                    busy,
  output logic                    done,
  output logic [DUTY_W-1:0]       quotient
);

  logic [CNT_W-1:0]  rem_q;
  logic [CNT_W-1:0]  den_q;
  logic [DUTY_W-1:0] low_q;
  logic [DUTY_W-1:0] quo_q;
  logic [3:0]        iter_q;
  logic [CNT_W:0]    trial;
  logic [CNT_W:0]    diff;
  logic              bit_n;

  // Quotient never exceeds 1000 < 2^DUTY_W, so the upper numerator bits
  // are already smaller than the denominator and seed the remainder directly.
  always_comb begin
    trial = {rem_q, low_q[DUTY_W-1]};
    diff  = trial - {1'b0, den_q};
    bit_n = (trial >= {1'b0, den_q});
  end

  assign done     = busy && (iter_q == 4'(DIV_CYCLES - 1));
  assign quotient = {quo_q[DUTY_W-2:0], bit_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      iter_q <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      iter_q <= '0;
    end else if (busy) begin
      iter_q <= iter_q + 4'd1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start && !busy) begin
      rem_q <= numerator[CNT_W+DUTY_W-1:DUTY_W];
      low_q <= numerator[DUTY_W-1:0];
      den_q <= denominator;
      quo_q <= '0;
    end else if (busy) begin
      rem_q <= bit_n ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
      low_q <= {low_q[DUTY_W-2:0], 1'b0};
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period, high time and per-mille duty of an asynchronous PWM line.
// Optional PWM_GLITCH_FILTER_EN adds a 3-sample stability filter after the synchronizer.
module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_valid,
  output logic              timeout,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_MAX - 1'b1;

  logic [SYNC_STAGES-1:0]  sync_p0;
  logic                    synced;
  logic                    level;
  logic                    level_prev;
  logic                    rise;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_p_q, cnt_p_d;
  logic [CNT_W-1:0]        cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0]        idle_q, idle_d;
  logic                    capture;
  logic                    tmo_fire;
  logic [CNT_W-1:0]        cap_p_p1, cap_h_p1;
  logic [CNT_W+DUTY_W-1:0] num_p0;
  logic                    div_busy, div_done;
  logic [DUTY_W-1:0]       div_quot;

  // Stage: input synchronizer
  always_ff @(posedge clk) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pwm_in};
  end
  assign synced = sync_p0[SYNC_STAGES-1];

`ifdef PWM_GLITCH_FILTER_EN
  logic [FILT_LEN-2:0] hist_p0;
  logic                filt_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_p0 <= '0;
      filt_p0 <= 1'b0;
    end else begin
      hist_p0 <= {hist_p0[FILT_LEN-3:0], synced};
      if (&{hist_p0, synced})       filt_p0 <= 1'b1;
      else if (~|{hist_p0, synced}) filt_p0 <= 1'b0;
    end
  end
  assign level = filt_p0;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk) begin
    if (rst) level_prev <= 1'b0;
    else     level_prev <= level;
  end
  assign rise = level & ~level_prev;

  // Stage: measurement FSM and counters
  always_comb begin
    state_d  = state_q;
    cnt_p_d  = cnt_p_q;
    cnt_h_d  = cnt_h_q;
    idle_d   = idle_q;
    capture  = 1'b0;
    tmo_fire = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_p_d = '0;
        cnt_h_d = '0;
        if (rise) begin
          state_d = MEASURE;
          cnt_p_d = {{(CNT_W-1){1'b0}}, 1'b1};
          cnt_h_d = {{(CNT_W-1){1'b0}}, 1'b1};
          idle_d  = '0;
        end else if (idle_q == IDLE_LIMIT) begin
          tmo_fire = 1'b1;
          idle_d   = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          cnt_p_d = {{(CNT_W-1){1'b0}}, 1'b1};
          cnt_h_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_p_q == CNT_MAX) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
          cnt_p_d  = '0;
          cnt_h_d  = '0;
          idle_d   = '0;
        end else begin
          cnt_p_d = cnt_p_q + 1'b1;
          cnt_h_d = cnt_h_q + {{(CNT_W-1){1'b0}}, level};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_p_q <= '0;
      cnt_h_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_p_q <= cnt_p_d;
      cnt_h_q <= cnt_h_d;
      idle_q  <= idle_d;
    end
  end

  // Stage: capture into the divider; captures arriving while busy are dropped
  assign num_p0 = (CNT_W+DUTY_W)'(cnt_h_q) * (CNT_W+DUTY_W)'(DUTY_SCALE);

  always_ff @(posedge clk) begin
    if (capture && !div_busy) begin
      cap_p_p1 <= cnt_p_q;
      cap_h_p1 <= cnt_h_q;
    end
  end

  pwm_seq_divider #(
    .CNT_W(CNT_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (capture),
    .numerator   (num_p0),
    .denominator (cnt_p_q),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quot)
  );

  // Stage: result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (capture && div_busy) overrun <= 1'b1;
      if (rise) timeout <= 1'b0;
      if (tmo_fire) begin
        timeout    <= 1'b1;
        period     <= CNT_MAX;
        high_time  <= level ? CNT_MAX : '0;
        duty       <= level ? DUTY_W'(DUTY_SCALE) : '0;
        duty_valid <= 1'b1;
      end else if (div_done) begin
        period     <= cap_p_p1;
        high_time  <= cap_h_p1;
        duty       <= div_quot;
        duty_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: 16-bit instance for duty vectors, 8-bit instance for timeout.
module tb_pwm_duty_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_a = 1'b0;
  logic pwm_b = 1'b0;

  logic [15:0] period_a, high_a;
  logic [9:0]  duty_a;
  logic        vld_a, tmo_a, ovr_a;
  logic [7:0]  period_b, high_b;
  logic [9:0]  duty_b;
  logic        vld_b, tmo_b, ovr_b;

  always #5 clk = ~clk;

  pwm_duty_meter dut_a (
    .clk(clk), .rst(rst), .pwm_in(pwm_a),
    .period(period_a), .high_time(high_a), .duty(duty_a),
    .duty_valid(vld_a), .timeout(tmo_a), .overrun(ovr_a)
  );

  pwm_duty_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .pwm_in(pwm_b),
    .period(period_b), .high_time(high_b), .duty(duty_b),
    .duty_valid(vld_b), .timeout(tmo_b), .overrun(ovr_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_cnt = 0, ev_cyc = 0, ev_prev_cyc = 0;
  int ev_period = 0, ev_high = 0, ev_duty = 0;
  bit prev_vld = 1'b0;

  bit gen_en = 1'b0;
  bit man_a = 1'b0;
  int phase = 0;
  int gen_period = 100, gen_high = 50;
  int next_period = 100, next_high = 50;

  typedef struct {
    int per;
    int hi;
    int duty;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive pwm on the falling edge, sample just after the rising edge.
  task automatic step();
    @(negedge clk);
    if (gen_en) begin
      pwm_a = (phase < gen_high);
      phase++;
      if (phase >= gen_period) begin
        phase      = 0;
        gen_period = next_period;
        gen_high   = next_high;
      end
    end else begin
      pwm_a = man_a;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (vld_a) begin
      chk("vld_single_cycle", int'(prev_vld), 0);
      ev_prev_cyc = ev_cyc;
      ev_cyc      = cyc;
      ev_period   = int'(period_a);
      ev_high     = int'(high_a);
      ev_duty     = int'(duty_a);
      ev_cnt++;
    end
    prev_vld = vld_a;
  endtask

  task automatic wait_events(input int n, input int budget);
    int start_cnt;
    int c;
    start_cnt = ev_cnt;
    c = 0;
    while (ev_cnt < start_cnt + n && c < budget) begin
      step();
      c++;
    end
    chk("wait_events_in_budget", int'(ev_cnt >= start_cnt + n), 1);
  endtask

  initial begin
    int j;
    int k;
    int n0;

    vecs[0] = '{1000, 250, 250};
    vecs[1] = '{100,  33,  330};
    vecs[2] = '{100,  99,  990};
    vecs[3] = '{20,   7,   350};
    vecs[4] = '{37,   12,  324};
    vecs[5] = '{300,  299, 996};
    vecs[6] = '{12,   1,   83};

    rst = 1'b1;
    repeat (3) step();
    chk("rst_period",  int'(period_a), 0);
    chk("rst_high",    int'(high_a),   0);
    chk("rst_duty",    int'(duty_a),   0);
    chk("rst_valid",   int'(vld_a),    0);
    chk("rst_timeout", int'(tmo_a),    0);
    chk("rst_overrun", int'(ovr_a),    0);
    chk("rst_b_timeout", int'(tmo_b),  0);
    rst = 1'b0;

    // Timeout on the 8-bit instance: line goes high once and stays high.
    pwm_b = 1'b1;
    j = 0;
    while (!vld_b && j < 400) begin
      step();
      j++;
    end
    chk("b_timeout_latency", j, 258);
    chk("b_timeout_flag",    int'(tmo_b),    1);
    chk("b_timeout_period",  int'(period_b), 255);
    chk("b_timeout_high",    int'(high_b),   255);
    chk("b_timeout_duty",    int'(duty_b),   1000);
    step();
    chk("b_timeout_vld_pulse", int'(vld_b), 0);
    pwm_b = 1'b0;
    repeat (5) step();
    chk("b_timeout_holds_on_fall", int'(tmo_b), 1);
    pwm_b = 1'b1;
    repeat (4) step();
    chk("b_timeout_cleared_by_rise", int'(tmo_b), 0);
    pwm_b = 1'b0;

    // Capture-to-result latency on a hand-driven 100/40 period.
    man_a = 1'b1;
    repeat (40) step();
    man_a = 1'b0;
    repeat (60) step();
    man_a = 1'b1;
    j = 0;
    while (!vld_a && j < 40) begin
      step();
      j++;
    end
    chk("latency_pwm_to_valid", j, 13);
    chk("latency_period", int'(period_a), 100);
    chk("latency_high",   int'(high_a),   40);
    chk("latency_duty",   int'(duty_a),   400);

    // Table of steady-state waveforms.
    gen_period  = vecs[0].per;
    gen_high    = vecs[0].hi;
    next_period = vecs[0].per;
    next_high   = vecs[0].hi;
    phase       = 0;
    gen_en      = 1'b1;
    for (int i = 0; i < 7; i++) begin
      next_period = vecs[i].per;
      next_high   = vecs[i].hi;
      wait_events(3, 6000);
      chk("vec_period",  ev_period, vecs[i].per);
      chk("vec_high",    ev_high,   vecs[i].hi);
      chk("vec_duty",    ev_duty,   vecs[i].duty);
      chk("vec_spacing", ev_cyc - ev_prev_cyc, vecs[i].per);
      chk("vec_overrun", int'(ovr_a), 0);
    end

    // Period shorter than the divide: every other capture dropped.
    next_period = 8;
    next_high   = 4;
    wait_events(4, 2000);
    chk("ovr_flag",    int'(ovr_a), 1);
    chk("ovr_period",  ev_period, 8);
    chk("ovr_high",    ev_high,   4);
    chk("ovr_duty",    ev_duty,   500);
    chk("ovr_spacing", ev_cyc - ev_prev_cyc, 16);
    repeat (20) step();
    chk("ovr_sticky",  int'(ovr_a), 1);

    // Reset five cycles after a capture aborts the in-flight divide.
    next_period = 100;
    next_high   = 3;
    wait_events(3, 1500);
    chk("pre_rst_duty", ev_duty, 30);
    k = ev_cyc;
    while (cyc < k + 93) step();
    rst = 1'b1;
    step();
    chk("midrst_period",  int'(period_a), 0);
    chk("midrst_high",    int'(high_a),   0);
    chk("midrst_duty",    int'(duty_a),   0);
    chk("midrst_valid",   int'(vld_a),    0);
    chk("midrst_overrun", int'(ovr_a),    0);
    rst = 1'b0;
    n0 = ev_cnt;
    repeat (20) step();
    chk("no_valid_after_rst", ev_cnt - n0, 0);
    wait_events(1, 400);
    chk("resume_period", ev_period, 100);
    chk("resume_high",   ev_high,   3);
    chk("resume_duty",   ev_duty,   30);
    chk("resume_overrun", int'(ovr_a), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
